// File: rtl/decode_stage_pkg.sv
// Shared encodings, ID/EX payload and immediate helper for the RV32I decode stage.
package decode_stage_pkg;

  localparam int unsigned XLEN_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned WB_SEL_W = 2;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd10;

  localparam logic [WB_SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [WB_SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [WB_SEL_W-1:0] WB_PC4 = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_KILL = 2'd2
  } dec_state_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN_W-1:0]   pc;
    logic [XLEN_W-1:0]   rs1_data;
    logic [XLEN_W-1:0]   rs2_data;
    logic [XLEN_W-1:0]   imm;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [REG_W-1:0]    rd;
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic [2:0]          funct3;
    logic                mem_read;
    logic                mem_write;
    logic                reg_write;
    logic                branch;
    logic                jump;
    logic [WB_SEL_W-1:0] wb_sel;
  } id_ex_t;

  // funct3 -> ALU op; alt is inst[30], which only selects SUB for register-register ops
  function automatic logic [ALU_OP_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt,
                                                      input logic is_op);
    logic [ALU_OP_W-1:0] op;
    case (f3)
      F3_ADD:  op = (is_op && alt) ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Sign-extended immediate for the instruction's format; zero for R-type and unknown opcodes
  function automatic logic [XLEN_W-1:0] gen_imm(input logic [XLEN_W-1:0] inst);
    logic [XLEN_W-1:0] imm;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC:            imm = {inst[31:12], 12'h000};
      OPC_JAL:                       imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OPIMM: imm = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:                     imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:                    imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      default:                       imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 register file, two combinational read ports, one write port, write-back bypass on reads.
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              i_we,
  input  logic [REG_W-1:0]  i_waddr,
  input  logic [XLEN_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_raddr1,
  input  logic [REG_W-1:0]  i_raddr2,
  output logic [XLEN_W-1:0] o_rdata1_c,
  output logic [XLEN_W-1:0] o_rdata2_c
);

  logic [XLEN_W-1:0] mem_q [32];

  // Storage is intentionally not reset; x0 is never written
  always_ff @(posedge clk) begin
    if (i_we && (i_waddr != '0)) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_rdata1_c = '0;
    o_rdata2_c = '0;
    if (i_raddr1 != '0) begin
      o_rdata1_c = (i_we && (i_waddr == i_raddr1)) ? i_wdata : mem_q[i_raddr1];
    end
    if (i_raddr2 != '0) begin
      o_rdata2_c = (i_we && (i_waddr == i_raddr2)) ? i_wdata : mem_q[i_raddr2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: fetch register -> decode/regfile read -> ID/EX register,
// with load-use stall (RUN/HOLD) and branch-flush squash (KILL).
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [XLEN-1:0]       i_pipe_PC,
  input  logic [XLEN-1:0]       i_pipe_Instruction,
  input  logic                  i_flush,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic                  o_stall,
  output logic                  o_pipe_valid,
  output logic [XLEN-1:0]       o_pipe_PC,
  output logic [XLEN-1:0]       o_pipe_rs1_data,
  output logic [XLEN-1:0]       o_pipe_rs2_data,
  output logic [XLEN-1:0]       o_pipe_imm,
  output logic [REG_ADDR_W-1:0] o_pipe_rs1,
  output logic [REG_ADDR_W-1:0] o_pipe_rs2,
  output logic [REG_ADDR_W-1:0] o_pipe_rd,
  output logic [3:0]            o_pipe_alu_op,
  output logic                  o_pipe_alu_src,
  output logic [2:0]            o_pipe_funct3,
  output logic                  o_pipe_mem_read,
  output logic                  o_pipe_mem_write,
  output logic                  o_pipe_reg_write,
  output logic                  o_pipe_branch,
  output logic                  o_pipe_jump,
  output logic [1:0]            o_pipe_wb_sel,
  output logic                  o_illegal
);

  dec_state_e        state_q, state_d;
  logic [XLEN_W-1:0] hold_inst_q, hold_inst_d;
  logic [XLEN_W-1:0] hold_pc_q, hold_pc_d;
  id_ex_t            id_ex_q, id_ex_d;
  logic              illegal_q, illegal_d;

  logic [XLEN_W-1:0] sel_inst;
  logic [XLEN_W-1:0] sel_pc;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  id_ex_t            dec;
  id_ex_t            dec_full;
  logic              dec_illegal;
  logic              use_rs1;
  logic              use_rs2;
  logic [XLEN_W-1:0] rf_rdata1;
  logic [XLEN_W-1:0] rf_rdata2;
  logic              hazard;
  logic              stall_c;

  // HOLD replays the instruction that was stalled; otherwise decode the fetch register
  assign sel_inst = (state_q == ST_HOLD) ? hold_inst_q : i_pipe_Instruction;
  assign sel_pc   = (state_q == ST_HOLD) ? hold_pc_q   : i_pipe_PC;
  assign opcode   = sel_inst[6:0];
  assign funct3   = sel_inst[14:12];

  always_comb begin : decode_comb
    dec         = '0;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    if (sel_inst != '0) begin
      dec.valid  = 1'b1;
      dec.pc     = sel_pc;
      dec.funct3 = funct3;
      dec.imm    = gen_imm(sel_inst);
      case (opcode)
        OPC_LUI: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_op    = ALU_PASSB;
        end
        OPC_AUIPC: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
        end
        OPC_JAL: begin
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.wb_sel    = WB_PC4;
        end
        OPC_JALR: begin
          dec.reg_write = 1'b1;
          dec.jump      = 1'b1;
          dec.alu_src   = 1'b1;
          dec.wb_sel    = WB_PC4;
          use_rs1       = 1'b1;
        end
        OPC_BRANCH: begin
          dec.branch = 1'b1;
          dec.alu_op = ALU_SUB;
          use_rs1    = 1'b1;
          use_rs2    = 1'b1;
        end
        OPC_LOAD: begin
          dec.reg_write = 1'b1;
          dec.mem_read  = 1'b1;
          dec.alu_src   = 1'b1;
          dec.wb_sel    = WB_MEM;
          use_rs1       = 1'b1;
        end
        OPC_STORE: begin
          dec.mem_write = 1'b1;
          dec.alu_src   = 1'b1;
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
        OPC_OPIMM: begin
          dec.reg_write = 1'b1;
          dec.alu_src   = 1'b1;
          dec.alu_op    = alu_from_f3(funct3, sel_inst[30], 1'b0);
          use_rs1       = 1'b1;
        end
        OPC_OP: begin
          dec.reg_write = 1'b1;
          dec.alu_op    = alu_from_f3(funct3, sel_inst[30], 1'b1);
          use_rs1       = 1'b1;
          use_rs2       = 1'b1;
        end
        default: begin
          // Unsupported opcode: still a valid slot so execute sees it, but with no side effects
          dec_illegal = 1'b1;
          dec.funct3  = '0;
          dec.imm     = '0;
        end
      endcase
      // Unused index fields stay zero, so they never trip the load-use compare
      dec.rs1 = use_rs1 ? sel_inst[19:15] : '0;
      dec.rs2 = use_rs2 ? sel_inst[24:20] : '0;
      dec.rd  = dec.reg_write ? sel_inst[11:7] : '0;
    end
  end

  decode_stage_regfile u_regfile (
    .clk        (clk),
    .i_we       (i_wb_en),
    .i_waddr    (i_wb_rd),
    .i_wdata    (i_wb_data),
    .i_raddr1   (dec.rs1),
    .i_raddr2   (dec.rs2),
    .o_rdata1_c (rf_rdata1),
    .o_rdata2_c (rf_rdata2)
  );

  always_comb begin
    dec_full          = dec;
    dec_full.rs1_data = rf_rdata1;
    dec_full.rs2_data = rf_rdata2;
  end

  assign hazard = id_ex_q.valid && id_ex_q.mem_read && (id_ex_q.rd != '0) &&
                  ((dec.rs1 == id_ex_q.rd) || (dec.rs2 == id_ex_q.rd));

  // Next-state and ID/EX selection; flush overrides everything, including a load-use stall
  always_comb begin : next_comb
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    id_ex_d     = '0;
    illegal_d   = 1'b0;
    stall_c     = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (hazard) begin
          stall_c     = 1'b1;
          hold_inst_d = i_pipe_Instruction;
          hold_pc_d   = i_pipe_PC;
          state_d     = ST_HOLD;
        end else begin
          id_ex_d   = dec_full;
          illegal_d = dec_illegal;
        end
      end
      ST_HOLD: begin
        id_ex_d     = dec_full;
        illegal_d   = dec_illegal;
        hold_inst_d = '0;
        hold_pc_d   = '0;
        state_d     = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    if (i_flush) begin
      id_ex_d     = '0;
      illegal_d   = 1'b0;
      stall_c     = 1'b0;
      hold_inst_d = '0;
      hold_pc_d   = '0;
      state_d     = ST_KILL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
      id_ex_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
      id_ex_q     <= id_ex_d;
      illegal_q   <= illegal_d;
    end
  end

  assign o_stall          = stall_c;
  assign o_pipe_valid     = id_ex_q.valid;
  assign o_pipe_PC        = id_ex_q.pc;
  assign o_pipe_rs1_data  = id_ex_q.rs1_data;
  assign o_pipe_rs2_data  = id_ex_q.rs2_data;
  assign o_pipe_imm       = id_ex_q.imm;
  assign o_pipe_rs1       = id_ex_q.rs1;
  assign o_pipe_rs2       = id_ex_q.rs2;
  assign o_pipe_rd        = id_ex_q.rd;
  assign o_pipe_alu_op    = id_ex_q.alu_op;
  assign o_pipe_alu_src   = id_ex_q.alu_src;
  assign o_pipe_funct3    = id_ex_q.funct3;
  assign o_pipe_mem_read  = id_ex_q.mem_read;
  assign o_pipe_mem_write = id_ex_q.mem_write;
  assign o_pipe_reg_write = id_ex_q.reg_write;
  assign o_pipe_branch    = id_ex_q.branch;
  assign o_pipe_jump      = id_ex_q.jump;
  assign o_pipe_wb_sel    = id_ex_q.wb_sel;
  assign o_illegal        = illegal_q;

endmodule
